// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the halt encoding and the fetch FSM state type.
package fetch_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  // Instruction encoding that stops fetch once it has been delivered.
  localparam logic [31:0] HALT_WORD_DEF = 32'hD440_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, addresses the ROM, and registers
// the returned word together with its address as the pipeline register that
// feeds the core. Handles stall, branch redirect (one-bubble squash) and halt.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEF)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    program_counter,
  output logic               instr_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_t        state;
  logic [PC_W-1:0]     fetch_pc;
  logic [PC_W-1:0]     fetch_pc_inc;
  logic                rom_is_halt;
  logic                consume;

  // The ROM sees the fetch PC directly so a new address is read the same cycle.
  assign rom_addr = fetch_pc;

  // Next sequential address wraps naturally at 2^PC_W.
  assign fetch_pc_inc = fetch_pc + PC_W'(1);

  // Halt detection on the word currently being returned by the ROM.
  assign rom_is_halt = (rom_data == HALT_WORD);

  // The core takes the presented instruction on any edge where it is live and
  // neither held by a stall nor squashed by a redirect.
  assign consume = instr_valid && !stall && !branch_taken;

  // Fetch FSM together with the PC, pipeline register and delivered counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= BOOT;
      fetch_pc        <= RESET_PC;
      instruction     <= '0;
      program_counter <= '0;
      instr_valid     <= 1'b0;
      halted          <= 1'b0;
      fetch_count     <= '0;
    end else begin
      if (consume) begin
        fetch_count <= fetch_count + 32'd1;
      end

      unique case (state)
        BOOT: begin
          instruction     <= rom_data;
          program_counter <= fetch_pc;
          instr_valid     <= 1'b1;
          fetch_pc        <= fetch_pc_inc;
          state           <= rom_is_halt ? HALTED : RUN;
        end

        RUN: begin
          if (branch_taken) begin
            fetch_pc    <= branch_target;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instruction     <= rom_data;
            program_counter <= fetch_pc;
            instr_valid     <= 1'b1;
            fetch_pc        <= fetch_pc_inc;
            if (rom_is_halt) begin
              state <= HALTED;
            end
          end
        end

        HALTED: begin
          if (instr_valid && !stall) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end

        default: begin
          state       <= BOOT;
          fetch_pc    <= RESET_PC;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
